// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage and a synchronous IMEM.
// The fetch side drives the strobe and address; read data returns one cycle later.
interface pc_fetch_stage_if;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   modport master (
      output imem_en,
      output imem_addr,
      input  imem_rdata
   );

   modport slave (
      input  imem_en,
      input  imem_addr,
      output imem_rdata
   );
endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage feeding the loop detector and decoder.
// Issues sequential reads to a one-cycle-latency IMEM, freezes on replay or
// hazard stalls (parking at most one returning word in a skid entry), and
// redirects on loop exit or branch mispredict.
module pc_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               reset,
   pc_fetch_stage_if.master   imem,
   input  logic               block_signal,
   input  logic               bubble_idex,
   input  logic               flush,
   input  logic [31:0]        new_pc,
   input  logic               mispredict,
   input  logic [31:0]        mispredict_pc,
   output logic [31:0]        curr_PC,
   output logic [31:0]        instruction,
   output logic [31:0]        immediate,
   output logic               fetch_valid
);

   typedef enum logic {
      RUN,
      HOLD
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] pc_f;
   logic        req_v;
   logic [31:0] req_pc;
   logic        skid_v;
   logic [31:0] skid_pc;
   logic [31:0] skid_insn;

   logic        hold;
   logic        redir;
   logic        issue;
   logic [31:0] target;

   // Sign-extended byte offset for B-type and JAL; everything else decodes to 0.
   function automatic logic [31:0] decode_imm(input logic [31:0] i);
      logic [31:0] imm;
      imm = 32'd0;
      case (i[6:0])
         7'b1100011: imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
         7'b1101111: imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
         default:    imm = 32'd0;
      endcase
      return imm;
   endfunction

   // Control decode: redirects win over holds, and the release cycle of a hold
   // already issues so the parked word and the next fetch flow back-to-back.
   always_comb begin
      hold       = block_signal | bubble_idex;
      redir      = mispredict | flush;
      target     = (mispredict ? mispredict_pc : new_pc) & ~32'h3;
      issue      = reset & ~hold & ~redir;
      state_next = state;
      if (redir) begin
         state_next = RUN;
      end else if (hold) begin
         state_next = HOLD;
      end else begin
         state_next = RUN;
      end
   end

   assign imem.imem_en   = issue;
   assign imem.imem_addr = pc_f;

   // State register, PC/request tracking, skid entry and presented outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= RUN;
         pc_f        <= RESET_PC;
         req_v       <= 1'b0;
         req_pc      <= 32'd0;
         skid_v      <= 1'b0;
         skid_pc     <= 32'd0;
         skid_insn   <= 32'd0;
         curr_PC     <= 32'd0;
         instruction <= NOP_INSN;
         immediate   <= 32'd0;
         fetch_valid <= 1'b0;
      end else begin
         state <= state_next;
         req_v <= issue;
         if (issue) begin
            req_pc <= pc_f;
            pc_f   <= pc_f + 32'd4;
         end
         if (redir) begin
            pc_f        <= target;
            skid_v      <= 1'b0;
            fetch_valid <= 1'b0;
            instruction <= NOP_INSN;
            immediate   <= 32'd0;
         end else if (hold) begin
            if (req_v) begin
               skid_v    <= 1'b1;
               skid_pc   <= req_pc;
               skid_insn <= imem.imem_rdata;
            end
         end else if (state == HOLD && skid_v) begin
            skid_v      <= 1'b0;
            curr_PC     <= skid_pc;
            instruction <= skid_insn;
            immediate   <= decode_imm(skid_insn);
            fetch_valid <= 1'b1;
         end else if (req_v) begin
            curr_PC     <= req_pc;
            instruction <= imem.imem_rdata;
            immediate   <= decode_imm(imem.imem_rdata);
            fetch_valid <= 1'b1;
         end else begin
            fetch_valid <= 1'b0;
            instruction <= NOP_INSN;
            immediate   <= 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed, table-driven bench for pc_fetch_stage: a main instance at 0x100
// exercising hold/skid, flush, mispredict and immediate decode, and a second
// instance starting at 0xFFFFFFF8 to show PC wrap-around.
module tb_pc_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        block_signal;
   logic        bubble_idex;
   logic        flush;
   logic [31:0] new_pc;
   logic        mispredict;
   logic [31:0] mispredict_pc;

   logic [31:0] curr_PC;
   logic [31:0] instruction;
   logic [31:0] immediate;
   logic        fetch_valid;

   logic [31:0] w_curr_PC;
   logic [31:0] w_instruction;
   logic [31:0] w_immediate;
   logic        w_fetch_valid;

   int checks = 0;
   int errors = 0;

   pc_fetch_stage_if bus_main ();
   pc_fetch_stage_if bus_wrap ();

   pc_fetch_stage #(.RESET_PC(32'h0000_0100), .NOP_INSN(NOP)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem          (bus_main.master),
      .block_signal  (block_signal),
      .bubble_idex   (bubble_idex),
      .flush         (flush),
      .new_pc        (new_pc),
      .mispredict    (mispredict),
      .mispredict_pc (mispredict_pc),
      .curr_PC       (curr_PC),
      .instruction   (instruction),
      .immediate     (immediate),
      .fetch_valid   (fetch_valid)
   );

   pc_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSN(NOP)) dut_wrap (
      .clk           (clk),
      .reset         (reset),
      .imem          (bus_wrap.master),
      .block_signal  (1'b0),
      .bubble_idex   (1'b0),
      .flush         (1'b0),
      .new_pc        (32'd0),
      .mispredict    (1'b0),
      .mispredict_pc (32'd0),
      .curr_PC       (w_curr_PC),
      .instruction   (w_instruction),
      .immediate     (w_immediate),
      .fetch_valid   (w_fetch_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: a few hand-placed branch/jump words, otherwise an ADDI
   // whose upper bits encode the address so every fetch is identifiable.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      case (a)
         32'h0000_0100: w = 32'h0000_0013;
         32'h0000_010C: w = 32'hFE00_0AE3;
         32'h0000_0114: w = 32'h0080_006F;
         32'h0000_0118: w = 32'hFF9F_F06F;
         default:       w = {a[26:2], 7'b0010011};
      endcase
      return w;
   endfunction

   // Synchronous instruction memories for both instances.
   always @(posedge clk) begin
      if (bus_main.imem_en) bus_main.imem_rdata <= mem_word(bus_main.imem_addr);
      if (bus_wrap.imem_en) bus_wrap.imem_rdata <= mem_word(bus_wrap.imem_addr);
   end

   typedef struct {
      logic        rst;
      logic        blk;
      logic        bub;
      logic        fl;
      logic [31:0] npc;
      logic        mp;
      logic [31:0] mppc;
      logic        en;
      logic [31:0] addr;
      logic        fv;
      logic [31:0] cpc;
      logic [31:0] insn;
      logic [31:0] imm;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs [NVEC];

   function automatic vec_t make_vec(
      input logic rst, input logic blk, input logic bub, input logic fl,
      input logic [31:0] npc, input logic mp, input logic [31:0] mppc,
      input logic en, input logic [31:0] addr, input logic fv,
      input logic [31:0] cpc, input logic [31:0] insn, input logic [31:0] imm);
      vec_t v;
      v.rst = rst;  v.blk = blk;   v.bub = bub;   v.fl = fl;
      v.npc = npc;  v.mp = mp;     v.mppc = mppc;
      v.en = en;    v.addr = addr; v.fv = fv;
      v.cpc = cpc;  v.insn = insn; v.imm = imm;
      return v;
   endfunction

   task automatic apply_stimulus(input vec_t v);
      reset         = v.rst;
      block_signal  = v.blk;
      bubble_idex   = v.bub;
      flush         = v.fl;
      new_pc        = v.npc;
      mispredict    = v.mp;
      mispredict_pc = v.mppc;
   endtask

   task automatic check_output(input string name, input int row,
                               input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s (row %0d): got %h, want %h", name, row, actual, expected);
      end
   endtask

   task automatic check_reset_state(input int row);
      check_output("rst_imem_en", row, {31'd0, bus_main.imem_en}, 32'd0);
      check_output("rst_imem_addr", row, bus_main.imem_addr, 32'h100);
      check_output("rst_fetch_valid", row, {31'd0, fetch_valid}, 32'd0);
      check_output("rst_curr_PC", row, curr_PC, 32'd0);
      check_output("rst_instruction", row, instruction, NOP);
      check_output("rst_immediate", row, immediate, 32'd0);
      check_output("rst_wrap_imem_en", row, {31'd0, bus_wrap.imem_en}, 32'd0);
   endtask

   logic [31:0] wrap_addr [5];
   logic [31:0] wrap_cpc  [5];
   logic        wrap_fv   [5];

   initial begin
      // rst blk bub fl npc mp mppc | en addr fv cpc insn imm
      vecs[0]  = make_vec(1,0,0,0,0,0,0, 1,32'h100, 0,32'h0,  NOP,0);
      vecs[1]  = make_vec(1,0,0,0,0,0,0, 1,32'h104, 0,32'h0,  NOP,0);
      vecs[2]  = make_vec(1,1,0,0,0,0,0, 0,32'h108, 1,32'h100,mem_word(32'h100),0);
      vecs[3]  = make_vec(1,1,0,0,0,0,0, 0,32'h108, 1,32'h100,mem_word(32'h100),0);
      vecs[4]  = make_vec(1,1,0,0,0,0,0, 0,32'h108, 1,32'h100,mem_word(32'h100),0);
      vecs[5]  = make_vec(1,0,0,0,0,0,0, 1,32'h108, 1,32'h100,mem_word(32'h100),0);
      vecs[6]  = make_vec(1,0,0,0,0,0,0, 1,32'h10C, 1,32'h104,mem_word(32'h104),0);
      vecs[7]  = make_vec(1,0,0,0,0,0,0, 1,32'h110, 1,32'h108,mem_word(32'h108),0);
      vecs[8]  = make_vec(1,0,0,1,32'h110,0,0, 0,32'h114, 1,32'h10C,32'hFE000AE3,32'hFFFFFFF4);
      vecs[9]  = make_vec(1,0,0,0,0,0,0, 1,32'h110, 0,32'h10C,NOP,0);
      vecs[10] = make_vec(1,0,0,0,0,0,0, 1,32'h114, 0,32'h10C,NOP,0);
      vecs[11] = make_vec(1,0,0,0,0,0,0, 1,32'h118, 1,32'h110,mem_word(32'h110),0);
      vecs[12] = make_vec(1,1,0,1,32'h110,1,32'h200, 0,32'h11C, 1,32'h114,32'h0080006F,32'h8);
      vecs[13] = make_vec(1,1,0,0,0,0,0, 0,32'h200, 0,32'h114,NOP,0);
      vecs[14] = make_vec(1,0,0,0,0,0,0, 1,32'h200, 0,32'h114,NOP,0);
      vecs[15] = make_vec(1,0,0,0,0,0,0, 1,32'h204, 0,32'h114,NOP,0);
      vecs[16] = make_vec(1,0,1,0,0,0,0, 0,32'h208, 1,32'h200,mem_word(32'h200),0);
      vecs[17] = make_vec(1,0,0,0,0,0,0, 1,32'h208, 1,32'h200,mem_word(32'h200),0);
      vecs[18] = make_vec(1,0,0,0,0,0,0, 1,32'h20C, 1,32'h204,mem_word(32'h204),0);
      vecs[19] = make_vec(1,0,0,0,0,1,32'h11A, 0,32'h210, 1,32'h208,mem_word(32'h208),0);
      vecs[20] = make_vec(1,0,0,0,0,0,0, 1,32'h118, 0,32'h208,NOP,0);
      vecs[21] = make_vec(1,0,0,0,0,0,0, 1,32'h11C, 0,32'h208,NOP,0);
      vecs[22] = make_vec(1,0,0,0,0,0,0, 1,32'h120, 1,32'h118,32'hFF9FF06F,32'hFFFFFFF8);
      vecs[23] = make_vec(0,0,0,0,0,0,0, 0,32'h124, 1,32'h11C,mem_word(32'h11C),0);
      vecs[24] = make_vec(1,0,0,0,0,0,0, 1,32'h100, 0,32'h0,  NOP,0);

      wrap_addr[0] = 32'hFFFFFFF8; wrap_cpc[0] = 32'h0;        wrap_fv[0] = 1'b0;
      wrap_addr[1] = 32'hFFFFFFFC; wrap_cpc[1] = 32'h0;        wrap_fv[1] = 1'b0;
      wrap_addr[2] = 32'h00000000; wrap_cpc[2] = 32'hFFFFFFF8; wrap_fv[2] = 1'b1;
      wrap_addr[3] = 32'h00000004; wrap_cpc[3] = 32'hFFFFFFFC; wrap_fv[3] = 1'b1;
      wrap_addr[4] = 32'h00000008; wrap_cpc[4] = 32'h00000000; wrap_fv[4] = 1'b1;

      apply_stimulus(make_vec(0,0,0,0,0,0,0, 0,0,0,0,0,0));
      @(negedge clk);
      @(negedge clk);
      #1;
      check_reset_state(-1);

      for (int r = 0; r < NVEC; r++) begin
         @(negedge clk);
         apply_stimulus(vecs[r]);
         #1;
         check_output("imem_en", r, {31'd0, bus_main.imem_en}, {31'd0, vecs[r].en});
         check_output("imem_addr", r, bus_main.imem_addr, vecs[r].addr);
         check_output("fetch_valid", r, {31'd0, fetch_valid}, {31'd0, vecs[r].fv});
         check_output("curr_PC", r, curr_PC, vecs[r].cpc);
         check_output("instruction", r, instruction, vecs[r].insn);
         check_output("immediate", r, immediate, vecs[r].imm);
      end

      // Wrap-around sequence on the second instance after a fresh reset.
      @(negedge clk);
      apply_stimulus(make_vec(0,0,0,0,0,0,0, 0,0,0,0,0,0));
      @(negedge clk);
      @(negedge clk);
      #1;
      check_reset_state(100);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         reset = 1'b1;
         #1;
         check_output("wrap_imem_en", 200 + k, {31'd0, bus_wrap.imem_en}, 32'd1);
         check_output("wrap_imem_addr", 200 + k, bus_wrap.imem_addr, wrap_addr[k]);
         check_output("wrap_curr_PC", 200 + k, w_curr_PC, wrap_cpc[k]);
         check_output("wrap_fetch_valid", 200 + k, {31'd0, w_fetch_valid}, {31'd0, wrap_fv[k]});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
